// File: rtl/ab_sweep_pkg.sv
// Shared types and constants for the A/B sweep stimulus generator.
`default_nettype none

package ab_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GUARD_S = 3'd1,
    PULSE_S = 3'd2,
    HOLD_S  = 3'd3,
    DONE_S  = 3'd4
  } state_t;

  localparam int DWELL_DEF = 16;
  localparam int GUARD_DEF = 2;
  localparam int PULSE_DEF = 3;
  localparam int CW_DEF    = 8;

  // Phase index -> {A,B}, packed two bits per phase: 00, 01, 11, 10
  localparam logic [7:0] GRAY_AB_TABLE = 8'b10_11_01_00;

  function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
    return GRAY_AB_TABLE[{phase, 1'b0} +: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ab_sweep_gen_timer.sv
// Per-phase cycle counter; emits guard/pulse/dwell end strobes.
`default_nettype none

module ab_phase_timer #(
  parameter int DWELL = 16,
  parameter int GUARD = 2,
  parameter int PULSE = 3,
  parameter int CW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic guard_end,
  output logic pulse_end,
  output logic dwell_end
);

  logic [CW-1:0] cnt;

  // Counts total cycles of the current phase, independent of FSM sub-state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= dwell_end ? '0 : cnt + 1'b1;
    end
  end

  assign guard_end = (cnt == CW'(GUARD - 1));
  assign pulse_end = (cnt == CW'(GUARD + PULSE - 1));
  assign dwell_end = (cnt == CW'(DWELL - 1));

endmodule

`default_nettype wire

// File: rtl/ab_sweep_gen.sv
// A/B Gray-order sweep with masked active-low X pulses per phase.
// Optional macro AB_SWEEP_REPEAT_EN: loop continuously, pulsed DONE, START stops.
`default_nettype none

module ab_sweep_gen
  import ab_sweep_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int PULSE = PULSE_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  output logic       a,
  output logic       b,
  output logic       x,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] mask_q, mask_d;
  logic       a_d, b_d, x_d, busy_d, done_d;
  logic       timer_clear, timer_run;
  logic       guard_end, pulse_end, dwell_end;

  ab_phase_timer #(
    .DWELL(DWELL), .GUARD(GUARD), .PULSE(PULSE), .CW(CW)
  ) u_timer (
    .clk(clk), .rst_n(rst_n), .clear(timer_clear), .run(timer_run),
    .guard_end(guard_end), .pulse_end(pulse_end), .dwell_end(dwell_end)
  );

`ifdef AB_SWEEP_REPEAT_EN
  logic stop_q, stop_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      mask_q  <= 4'd0;
      a       <= 1'b0;
      b       <= 1'b0;
      x       <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef AB_SWEEP_REPEAT_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      a       <= a_d;
      b       <= b_d;
      x       <= x_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef AB_SWEEP_REPEAT_EN
      stop_q  <= stop_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    mask_d      = mask_q;
    a_d         = a;
    b_d         = b;
    x_d         = x;
    busy_d      = busy;
    done_d      = done;
    timer_clear = 1'b0;
    timer_run   = 1'b0;
`ifdef AB_SWEEP_REPEAT_EN
    done_d      = 1'b0;
    stop_d      = stop_q | (busy & start);
`endif

    case (state_q)
      IDLE, DONE_S: begin
        if (start) begin
          mask_d      = mask;
          phase_d     = 2'd0;
          {a_d, b_d}  = phase_to_ab(2'd0);
          x_d         = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          timer_clear = 1'b1;
          state_d     = GUARD_S;
        end
      end
      GUARD_S: begin
        timer_run = 1'b1;
        if (guard_end) begin
          if (mask_q[phase_q]) begin
            x_d     = 1'b0;
            state_d = PULSE_S;
          end else begin
            state_d = HOLD_S;
          end
        end
      end
      PULSE_S: begin
        timer_run = 1'b1;
        if (pulse_end) begin
          x_d     = 1'b1;
          state_d = HOLD_S;
        end
      end
      HOLD_S: begin
        timer_run = 1'b1;
        if (dwell_end) begin
`ifdef AB_SWEEP_REPEAT_EN
          phase_d    = phase_q + 2'd1;
          {a_d, b_d} = phase_to_ab(phase_q + 2'd1);
          state_d    = GUARD_S;
          if (phase_q == 2'd3) begin
            done_d = 1'b1;
          end
          // A pending stop ends the sweep at this phase boundary
          if (stop_q) begin
            phase_d    = 2'd0;
            {a_d, b_d} = phase_to_ab(2'd0);
            busy_d     = 1'b0;
            stop_d     = 1'b0;
            state_d    = IDLE;
          end
`else
          if (phase_q == 2'd3) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE_S;
          end else begin
            phase_d    = phase_q + 2'd1;
            {a_d, b_d} = phase_to_ab(phase_q + 2'd1);
            state_d    = GUARD_S;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ab_sweep_gen.sv
// Directed bench for ab_sweep_gen (default single-sweep build).
`default_nettype none

module tb_ab_sweep_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mask = 4'd0;
  logic       a, b, x, busy, done;

  int n_checks = 0;
  int n_fails  = 0;

  ab_sweep_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask),
    .a(a), .b(b), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Accept START on the next edge; returns 1 time unit after it (cycle 0)
  task automatic start_sweep(input logic [3:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [1:0] exp_ab(input int k);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    return (k >= 64) ? 2'b10 : seq[k / 16];
  endfunction

  function automatic logic exp_x(input int k, input logic [3:0] m);
    int ph, off;
    ph  = k / 16;
    off = k % 16;
    if (k >= 64) return 1'b1;
    return !(m[ph] && off >= 2 && off <= 4);
  endfunction

  // Check every cycle k=0..last of a sweep; optionally re-pulse START at cycle restart_at
  task automatic run_sweep(input logic [3:0] m, input int last, input int restart_at);
    for (int k = 0; k <= last; k++) begin
      check_eq($sformatf("ab k=%0d", k), {30'd0, a, b}, {30'd0, exp_ab(k)});
      check_eq($sformatf("x k=%0d", k), {31'd0, x}, {31'd0, exp_x(k, m)});
      check_eq($sformatf("busy k=%0d", k), {31'd0, busy}, {31'd0, (k < 64)});
      check_eq($sformatf("done k=%0d", k), {31'd0, done}, {31'd0, (k >= 64)});
      if (k == restart_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #12;
    check_eq("reset a", {31'd0, a}, 32'd0);
    check_eq("reset b", {31'd0, b}, 32'd0);
    check_eq("reset x", {31'd0, x}, 32'd1);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Full mask, START re-asserted mid-sweep must be ignored
    start_sweep(4'b1111);
    run_sweep(4'b1111, 66, 10);

    // START while DONE is high restarts; sparse mask
    start_sweep(4'b0101);
    run_sweep(4'b0101, 66, -1);

    // Asynchronous reset in phase 2 during the X pulse
    start_sweep(4'b1111);
    repeat (35) @(posedge clk);
    #1;
    check_eq("mid ab", {30'd0, a, b}, 32'd3);
    check_eq("mid x", {31'd0, x}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async a", {31'd0, a}, 32'd0);
    check_eq("async b", {31'd0, b}, 32'd0);
    check_eq("async x", {31'd0, x}, 32'd1);
    check_eq("async busy", {31'd0, busy}, 32'd0);
    check_eq("async done", {31'd0, done}, 32'd0);
    #2 rst_n = 1'b1;

    start_sweep(4'b0001);
    run_sweep(4'b0001, 20, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ab_sweep_gen.md
Name: ab_sweep_gen

Overview:
- Stimulus transmitter for the A/B-qualified X-glitch filter.
- On a start request it steps the condition lines A,B through all four combinations in Gray order: 00 -> 01 -> 11 -> 10.
- In each phase it can drive a programmable active-low pulse on X, selected by a 4-bit mask, so each sticky latch of the filter can be exercised or deliberately skipped.
- Sits on the stimulus side of the filter in lab benches and in self-test wrappers; signals completion with a DONE flag.

Parameters:
- DWELL, 16: total cycles each A/B phase is held; must be >= GUARD+PULSE+1.
- GUARD, 2: settle cycles after an A/B change before X may go low.
- PULSE, 3: width in cycles of the X low pulse.
- CW, 8: counter width; must satisfy 2**CW > DWELL.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle sweep request; sampled only in IDLE or DONE.
- MASK  in  4  per-phase pulse enable; bit i enables the pulse in phase i (0:AB=00, 1:01, 2:11, 3:10); captured on accepted START.
- A  out  1  condition line A, registered.
- B  out  1  condition line B, registered.
- X  out  1  test line, idle high, registered.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  sticky completion flag; cleared by the next accepted START.

Behaviour:
- Reset: A=0, B=0, X=1, BUSY=0, DONE=0, state=IDLE, phase=0, cnt=0, mask_q=0. Reset acts immediately and asynchronously, including mid-sweep; no outputs glitch after release.
- States: IDLE, GUARD_S, PULSE_S, HOLD_S, DONE_S.
- IDLE/DONE_S with START=1:
  - next edge: mask_q<=MASK, phase<=0, A=0, B=0, cnt<=0, BUSY=1, DONE=0, state<=GUARD_S.
- GUARD_S:
  - cnt counts up.
  - At cnt==GUARD-1: if mask_q[phase], go to PULSE_S and drive X=0 on the same edge; otherwise go to HOLD_S.
  - cnt keeps counting across states within a phase; it counts total phase cycles.
- PULSE_S:
  - X=0 for exactly PULSE cycles (cnt GUARD..GUARD+PULSE-1).
  - Then X=1 and state<=HOLD_S.
- HOLD_S:
  - At cnt==DWELL-1: cnt<=0.
  - If phase==3, go to DONE_S (BUSY=0, DONE=1, A/B keep 10).
  - Else phase+1, A/B update to the next Gray code on that edge, state<=GUARD_S.
- Invariants:
  - A and B never change while X=0; X is never low in the first GUARD or last cycle of a phase.
  - Exactly one of A,B toggles per phase boundary.
  - DONE asserts exactly 4*DWELL cycles after the START edge.
- START during BUSY: ignored; no restart, no error.
- START coincident with DONE_S entry: not accepted until the cycle after DONE=1 is visible.
- MASK changes mid-sweep: no effect; only mask_q is used.
- Phase counter is 2 bits and wraps 3 -> 0 only through DONE_S or the repeat path.

Optional Feature:
- Macro: AB_SWEEP_REPEAT_EN.
- Defined: on finishing phase 3, the block returns to phase 0 (A=0, B=0) and continues without DONE_S, pulsing DONE high for one cycle per completed sweep instead of holding it sticky. BUSY stays 1. START=1 while BUSY is treated as stop: it finishes the current phase, then goes to IDLE with A=0, B=0.
- Undefined: single sweep, sticky DONE as described above.

Decomposition:
- Shared package ab_sweep_pkg:
  - state enum (IDLE, GUARD_S, PULSE_S, HOLD_S, DONE_S);
  - Gray phase-to-AB constant table {00,01,11,10};
  - default DWELL/GUARD/PULSE constants.
- One natural sub-module: ab_phase_timer. It holds the CW-bit cycle counter and emits guard_end, pulse_end and dwell_end strobes. The top FSM consumes the strobes and owns A/B/X/BUSY/DONE.

Test Plan:
- Reset mid-sweep (RST_N low at phase 2, PULSE_S) -> A=0, B=0, X=1, BUSY=0, DONE=0 asynchronously; a new START then begins at phase 0.
- START with MASK=4'b1111, defaults -> A/B sequence 00,01,11,10, each for 16 cycles. Four X low pulses of 3 cycles, each starting 2 cycles after its phase start. DONE=1 at cycle 64 after START; A/B remain 10.
- MASK=4'b0101 -> X pulses only in phases 0 (AB=00) and 2 (AB=11); X=1 throughout AB=01 and AB=10.
- Drive A/B/X into the filter with MASK=4'b1111 -> filter output 0. With MASK=4'b0000 -> filter output stays 1.
- START re-asserted at cycle 10 of the sweep -> ignored; DONE still at cycle 64. START while DONE=1 -> DONE clears next edge and a new sweep runs.
- AB_SWEEP_REPEAT_EN defined, MASK=4'b1000 -> continuous looping; DONE single-cycle pulses at cycles 64, 128, 192. START at cycle 70 -> the phase ends at cycle 79, then IDLE with AB=00.
